pal_sync_monitor: RTL



---
 rtl/pal_sync_monitor.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pal_sync_monitor.sv
// pal_sync_monitor
//   Conditions the raw Amiga PAL sync/RGB stream before the PAL-to-DDR
//   upscaler. It measures the line period (clk cycles between falling hsync
//   edges) and the lines per field (hsync edges between falling vsync edges),
//   and declares lock after LOCK_FRAMES consecutive good fields. It also
//   forwards a copy of the stream delayed by exactly two clocks.
//
// Ports
//   clk, rst_n                     video clock, async active-low reset
//   i_pal_hsync, i_pal_vsync       raw PAL syncs (active-low)
//   i_pal_r/g/b [7:0]              raw PAL pixel data
//   o_pal_hsync, o_pal_vsync       syncs delayed by two clocks
//   o_pal_r/g/b [7:0]              pixel data delayed by two clocks
//   o_locked                       stable PAL timing detected
//   o_line_len [LINE_W-1:0]        last measured line period
//   o_frame_lines [LINES_W-1:0]    last measured lines per field
//
// Build option
//   PAL_SYNC_MONITOR_BLANK_EN  when defined, o_pal_r/g/b read 0 whenever
//                              o_locked is 0 (latency unchanged).

module pal_sync_monitor #(
  parameter int LINE_W      = 16,
  parameter int LINE_MIN    = 18000,
  parameter int LINE_MAX    = 20000,
  parameter int LINE_TOL    = 4,
  parameter int LINES_W     = 10,
  parameter int LINES_MIN   = 300,
  parameter int LINES_MAX   = 320,
  parameter int LOCK_FRAMES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_pal_hsync,
  input  logic               i_pal_vsync,
  input  logic [7:0]         i_pal_r,
  input  logic [7:0]         i_pal_g,
  input  logic [7:0]         i_pal_b,
  output logic               o_pal_hsync,
  output logic               o_pal_vsync,
  output logic [7:0]         o_pal_r,
  output logic [7:0]         o_pal_g,
  output logic [7:0]         o_pal_b,
  output logic               o_locked,
  output logic [LINE_W-1:0]  o_line_len,
  output logic [LINES_W-1:0] o_frame_lines
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [LINE_W-1:0]  LINE_SAT    = '1;
  localparam logic [LINE_W-1:0]  LINE_MIN_V  = LINE_W'(LINE_MIN);
  localparam logic [LINE_W-1:0]  LINE_MAX_V  = LINE_W'(LINE_MAX);
  localparam logic [LINE_W-1:0]  LINE_TOL_V  = LINE_W'(LINE_TOL);
  localparam logic [LINES_W-1:0] LINES_SAT   = '1;
  localparam logic [LINES_W-1:0] LINES_MIN_V = LINES_W'(LINES_MIN);
  localparam logic [LINES_W-1:0] LINES_MAX_V = LINES_W'(LINES_MAX);
  localparam logic [3:0]         LOCK_V      = 4'(LOCK_FRAMES);

  // Stage 1 (input register) and sync history for edge detection
  logic       s1_hs, s1_vs, hs_prev, vs_prev;
  logic [7:0] s1_r, s1_g, s1_b;
  // Stage 2 pixel register (syncs go straight to the output ports)
  logic [7:0] r_q, g_q, b_q;

  // Measurement state
  logic [LINE_W-1:0]  line_cnt;
  logic [LINES_W-1:0] field_cnt;
  logic               prev_valid;
  logic               bad_line;
  logic [3:0]         good_cnt, good_next;
  state_t             state, state_next;

  logic               hs_fall, vs_fall, timeout;
  logic [LINE_W-1:0]  line_diff;
  logic               line_good, line_bad_now;
  logic [LINES_W-1:0] field_lines_next;
  logic               field_bad;

  // Syncs reset to their idle (high) level so release from reset never
  // looks like a falling edge.
  // NOTE: every clocked process uses non-blocking assignments so all
  // registers sample the pre-edge values of each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      hs_prev     <= 1'b1;
      vs_prev     <= 1'b1;
      s1_r        <= '0;
      s1_g        <= '0;
      s1_b        <= '0;
      o_pal_hsync <= 1'b1;
      o_pal_vsync <= 1'b1;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
    end else begin
      s1_hs       <= i_pal_hsync;
      s1_vs       <= i_pal_vsync;
      hs_prev     <= s1_hs;
      vs_prev     <= s1_vs;
      s1_r        <= i_pal_r;
      s1_g        <= i_pal_g;
      s1_b        <= i_pal_b;
      o_pal_hsync <= s1_hs;
      o_pal_vsync <= s1_vs;
      r_q         <= s1_r;
      g_q         <= s1_g;
      b_q         <= s1_b;
    end
  end

  assign hs_fall = hs_prev & ~s1_hs;
  assign vs_fall = vs_prev & ~s1_vs;
  assign timeout = (line_cnt == LINE_SAT);

  // Line judgement against the range and the previously captured period.
  // NOTE: combinational blocks assign every output a default first so no
  // path through them can infer a latch.
  always_comb begin
    line_diff    = (line_cnt >= o_line_len) ? (line_cnt - o_line_len)
                                            : (o_line_len - line_cnt);
    line_good    = (line_cnt >= LINE_MIN_V) && (line_cnt <= LINE_MAX_V) &&
                   (!prev_valid || (line_diff <= LINE_TOL_V));
    line_bad_now = hs_fall && !line_good;

    // An hsync edge coincident with the vsync edge belongs to the ending field.
    field_lines_next = field_cnt;
    if (hs_fall && (field_cnt != LINES_SAT)) begin
      field_lines_next = field_cnt + 1'b1;
    end

    field_bad = bad_line || line_bad_now ||
                (field_lines_next < LINES_MIN_V) ||
                (field_lines_next > LINES_MAX_V);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt      <= '0;
      field_cnt     <= '0;
      o_line_len    <= '0;
      o_frame_lines <= '0;
      prev_valid    <= 1'b0;
      bad_line      <= 1'b0;
    end else begin
      if (hs_fall) begin
        line_cnt   <= LINE_W'(1);
        o_line_len <= line_cnt;
      end else if (!timeout) begin
        line_cnt <= line_cnt + 1'b1;
      end

      if (vs_fall) begin
        o_frame_lines <= field_lines_next;
        field_cnt     <= '0;
      end else begin
        field_cnt <= field_lines_next;
      end

      // While searching there is no trusted reference period, so the first
      // line judged after leaving SEARCH uses the range check alone.
      if (state == ST_SEARCH) begin
        prev_valid <= 1'b0;
      end else if (hs_fall) begin
        prev_valid <= 1'b1;
      end

      if (vs_fall) begin
        bad_line <= 1'b0;
      end else if (line_bad_now) begin
        bad_line <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    case (state)
      ST_SEARCH: begin
        if (vs_fall) begin
          state_next = ST_MEASURE;
          good_next  = '0;
        end
      end
      ST_MEASURE: begin
        if (vs_fall) begin
          if (field_bad) begin
            good_next = '0;
          end else begin
            good_next = good_cnt + 1'b1;
            if (good_next == LOCK_V) begin
              state_next = ST_LOCKED;
            end
          end
        end
      end
      ST_LOCKED: begin
        if (vs_fall && field_bad) begin
          state_next = ST_SEARCH;
          good_next  = '0;
        end
      end
      default: begin
        state_next = ST_SEARCH;
        good_next  = '0;
      end
    endcase
    // A saturated line counter means hsync has vanished; drop everything.
    if (timeout) begin
      state_next = ST_SEARCH;
      good_next  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
    end
  end

  // Decoded straight from the state register, so it moves on the same edge
  // as the measurement outputs.
  assign o_locked = (state == ST_LOCKED);

`ifdef PAL_SYNC_MONITOR_BLANK_EN
  assign o_pal_r = o_locked ? r_q : 8'd0;
  assign o_pal_g = o_locked ? g_q : 8'd0;
  assign o_pal_b = o_locked ? b_q : 8'd0;
`else
  assign o_pal_r = r_q;
  assign o_pal_g = g_q;
  assign o_pal_b = b_q;
`endif

endmodule
